// File: rtl/seg7_pkg.sv
// Shared constants, scan-state encoding and polarity helper for the 7-seg scan controller.
package seg7_pkg;

    localparam int unsigned SEG_W = 7;

    // Active-high segment pattern with every segment dark.
    localparam logic [SEG_W-1:0] SEG_OFF   = 7'b0000000;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b0000000;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } scan_state_t;

    // Map an active-high level onto the physical pin polarity.
    function automatic logic pol(input logic x, input logic act_low);
        return x ^ act_low;
    endfunction

endpackage

// File: rtl/seg7_scan_ctrl_hex_to_7seg.sv
// Active-high hex nibble to abcdefg segment decoder, [6] = a.
module hex_to_7seg (
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    // Standard hex font including lowercase b and d.
    always_comb begin
        seg = 7'b0000000;
        case (hex)
            4'h0: seg = 7'b1111110;
            4'h1: seg = 7'b0110000;
            4'h2: seg = 7'b1101101;
            4'h3: seg = 7'b1111001;
            4'h4: seg = 7'b0110011;
            4'h5: seg = 7'b1011011;
            4'h6: seg = 7'b1011111;
            4'h7: seg = 7'b1110000;
            4'h8: seg = 7'b1111111;
            4'h9: seg = 7'b1111011;
            4'hA: seg = 7'b1110111;
            4'hB: seg = 7'b0011111;
            4'hC: seg = 7'b1001110;
            4'hD: seg = 7'b0111101;
            4'hE: seg = 7'b1001111;
            4'hF: seg = 7'b1000111;
            default: seg = 7'b0000000;
        endcase
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed common-anode 7-seg scan controller with tear-free frame updates.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned DIGIT_CYCLES = 100000,
    parameter int unsigned BLANK_CYCLES = 1000,
    parameter bit          SEG_ACT_LOW  = 1'b1,
    parameter bit          AN_ACT_LOW   = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] data_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic                    blank_lz,
    input  logic                    load,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    upd_pend,
    output logic                    frame_done
);

    localparam int unsigned CNT_W  = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
    localparam int unsigned IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned DATA_W = 4 * NUM_DIGITS;

    scan_state_t             state_q, state_next;
    logic [CNT_W-1:0]        cnt_q, cnt_next;
    logic [IDX_W-1:0]        idx_q, idx_next;
    logic                    slot_end, frame_wrap;

    logic [DATA_W-1:0]       shadow_data_q, disp_data_q;
    logic [NUM_DIGITS-1:0]   shadow_dp_q, disp_dp_q;
    logic                    upd_pend_q;

    logic [NUM_DIGITS-1:0]   lit;
    logic                    upper_zero;
    logic [3:0]              cur_nibble;
    logic                    cur_lit;
    logic [6:0]              seg_ah;

    logic [6:0]              seg_next;
    logic                    dp_next;
    logic [NUM_DIGITS-1:0]   an_next;
    logic                    frame_done_next;

    logic [6:0]              seg_q;
    logic                    dp_q;
    logic [NUM_DIGITS-1:0]   an_q;
    logic                    frame_done_q;

    // Per-digit lit decision: enable mask plus leading-zero blanking from the top digit down.
    always_comb begin
        lit        = '0;
        upper_zero = 1'b1;
        for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
            upper_zero = upper_zero & (disp_data_q[4*i +: 4] == 4'h0);
            lit[i]     = digit_en[i] & ~(blank_lz & (i != 0) & upper_zero);
        end
    end

    assign cur_nibble = disp_data_q[{idx_q, 2'b00} +: 4];
    assign cur_lit    = lit[idx_q];

    hex_to_7seg u_hex_to_7seg (
        .hex (cur_nibble),
        .seg (seg_ah)
    );

    // Slot counter, digit index and scan state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_BLANK;
            cnt_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_next;
            cnt_q   <= cnt_next;
            idx_q   <= idx_next;
        end
    end

    // Next scan position and the registered-output values for the current position.
    always_comb begin
        cnt_next        = cnt_q + CNT_W'(1);
        idx_next        = idx_q;
        state_next      = ST_BLANK;
        seg_next        = '0;
        dp_next         = 1'b0;
        an_next         = '0;
        frame_done_next = 1'b0;

        slot_end   = (cnt_q == CNT_W'(DIGIT_CYCLES - 1));
        frame_wrap = slot_end && (idx_q == IDX_W'(NUM_DIGITS - 1));

        if (slot_end) begin
            cnt_next = '0;
            idx_next = frame_wrap ? '0 : idx_q + IDX_W'(1);
        end
        state_next = (cnt_next < CNT_W'(BLANK_CYCLES)) ? ST_BLANK : ST_DRIVE;

        for (int b = 0; b < 7; b++) begin
            seg_next[b] = pol(cur_lit ? seg_ah[b] : SEG_OFF[b], SEG_ACT_LOW);
        end
        dp_next = pol(cur_lit & disp_dp_q[idx_q], SEG_ACT_LOW);
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            an_next[i] = pol((state_q == ST_DRIVE) && cur_lit && (idx_q == IDX_W'(i)),
                             AN_ACT_LOW);
        end
        frame_done_next = frame_wrap;
    end

    // Shadow capture on load; shadow moves to the display only at the frame wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_data_q <= '0;
            shadow_dp_q   <= '0;
            disp_data_q   <= '0;
            disp_dp_q     <= '0;
            upd_pend_q    <= 1'b0;
        end else begin
            if (frame_wrap && upd_pend_q) begin
                disp_data_q <= shadow_data_q;
                disp_dp_q   <= shadow_dp_q;
                upd_pend_q  <= 1'b0;
            end
            if (load) begin
                shadow_data_q <= data_in;
                shadow_dp_q   <= dp_in;
                upd_pend_q    <= 1'b1;
            end
        end
    end

    // Output registers, one cycle behind the scan position.
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_q        <= {7{SEG_ACT_LOW}};
            dp_q         <= SEG_ACT_LOW;
            an_q         <= {NUM_DIGITS{AN_ACT_LOW}};
            frame_done_q <= 1'b0;
        end else begin
            seg_q        <= seg_next;
            dp_q         <= dp_next;
            an_q         <= an_next;
            frame_done_q <= frame_done_next;
        end
    end

    assign seg        = seg_q;
    assign dp         = dp_q;
    assign an         = an_q;
    assign upd_pend   = upd_pend_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl: behavioural model plus directed and random stimulus.
module tb_seg7_scan_ctrl;

    localparam int N  = 4;
    localparam int DC = 8;
    localparam int BC = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [15:0]   data_in;
    logic [3:0]    dp_in;
    logic [3:0]    digit_en;
    logic          blank_lz;
    logic          load;
    logic [6:0]    seg;
    logic          dp;
    logic [3:0]    an;
    logic          upd_pend;
    logic          frame_done;

    int n_cmp = 0;
    int n_bad = 0;

    seg7_scan_ctrl #(
        .NUM_DIGITS   (N),
        .DIGIT_CYCLES (DC),
        .BLANK_CYCLES (BC),
        .SEG_ACT_LOW  (1'b1),
        .AN_ACT_LOW   (1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .dp_in      (dp_in),
        .digit_en   (digit_en),
        .blank_lz   (blank_lz),
        .load       (load),
        .seg        (seg),
        .dp         (dp),
        .an         (an),
        .upd_pend   (upd_pend),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // Active-high abcdefg font, [6] = a.
    logic [6:0] font [16];
    initial begin
        font[0]  = 7'b1111110; font[1]  = 7'b0110000; font[2]  = 7'b1101101; font[3]  = 7'b1111001;
        font[4]  = 7'b0110011; font[5]  = 7'b1011011; font[6]  = 7'b1011111; font[7]  = 7'b1110000;
        font[8]  = 7'b1111111; font[9]  = 7'b1111011; font[10] = 7'b1110111; font[11] = 7'b0011111;
        font[12] = 7'b1001110; font[13] = 7'b0111101; font[14] = 7'b1001111; font[15] = 7'b1000111;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Behavioural model: scan position is just the count of edges since reset.
    int          pos;
    logic        valid = 1'b0;
    logic [15:0] m_disp, m_sh;
    logic [3:0]  m_ddp, m_sdp;
    logic        m_pend;
    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp, e_fd;

    always @(posedge clk) begin
        int c, i;
        logic l;
        logic [3:0] nib;
        if (rst) begin
            pos = 0; m_disp = '0; m_sh = '0; m_ddp = '0; m_sdp = '0; m_pend = 1'b0;
            e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_fd = 1'b0; valid = 1'b1;
        end else if (valid) begin
            c   = pos % DC;
            i   = (pos / DC) % N;
            l   = digit_en[i] && !(blank_lz && i != 0 && ((m_disp >> (4*i)) == 16'h0));
            nib = 4'(m_disp >> (4*i));
            e_an = 4'hF;
            if (l && c >= BC) e_an[i] = 1'b0;
            e_seg = l ? ~font[nib] : 7'h7F;
            e_dp  = !(l && m_ddp[i]);
            e_fd  = (c == DC-1) && (i == N-1);
            if (e_fd && m_pend) begin
                m_disp = m_sh; m_ddp = m_sdp; m_pend = 1'b0;
            end
            if (load) begin
                m_sh = data_in; m_sdp = dp_in; m_pend = 1'b1;
            end
            pos++;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (valid) begin
            chk("an", 32'(an), 32'(e_an));
            chk("seg", 32'(seg), 32'(e_seg));
            chk("dp", 32'(dp), 32'(e_dp));
            chk("frame_done", 32'(frame_done), 32'(e_fd));
            chk("upd_pend", 32'(upd_pend), 32'(m_pend));
        end
    end

    task automatic wait_fd();
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!frame_done && k < 100);
        if (!frame_done) chk("fd_timeout", 32'd0, 32'd1);
    endtask

    int lows [4];
    int dp_lows;

    // Count active-anode and active-dp cycles over one full frame.
    task automatic observe_frame();
        for (int d = 0; d < 4; d++) lows[d] = 0;
        dp_lows = 0;
        repeat (N*DC) begin
            @(negedge clk);
            for (int d = 0; d < 4; d++) if (!an[d]) lows[d]++;
            if (!dp) dp_lows++;
        end
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] p);
        data_in = d; dp_in = p; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    initial begin
        int gap;
        rst = 1'b1; data_in = '0; dp_in = '0; digit_en = 4'hF; blank_lz = 1'b0; load = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_an", 32'(an), 32'h0000000F);
        chk("rst_seg", 32'(seg), 32'h0000007F);
        chk("rst_dp", 32'(dp), 32'd1);
        chk("rst_pend", 32'(upd_pend), 32'd0);
        rst = 1'b0;

        // Load 1234 during the first frame; it shows from frame 2.
        do_load(16'h1234, 4'h0);
        chk("pend_after_load", 32'(upd_pend), 32'd1);
        wait_fd();
        chk("pend_after_wrap", 32'(upd_pend), 32'd0);
        gap = 0;
        do begin
            @(negedge clk);
            gap++;
        end while (!frame_done && gap < 100);
        chk("frame_period", 32'(gap), 32'd32);
        @(negedge clk);
        chk("slot0_blank", 32'(an), 32'hE ^ 32'h1);
        repeat (2) @(negedge clk);
        chk("d0_an", 32'(an), 32'b1110);
        chk("d0_seg_4", 32'(seg), 32'b1001100);
        repeat (25) @(negedge clk);
        chk("d3_an", 32'(an), 32'b0111);
        chk("d3_seg_1", 32'(seg), 32'b1001111);

        // Leading-zero blanking.
        blank_lz = 1'b1;
        do_load(16'h0050, 4'h0);
        wait_fd();
        observe_frame();
        chk("lz_d3", 32'(lows[3]), 32'd0);
        chk("lz_d2", 32'(lows[2]), 32'd0);
        chk("lz_d1", 32'(lows[1]), 32'd6);
        chk("lz_d0", 32'(lows[0]), 32'd6);
        do_load(16'h0000, 4'h0);
        wait_fd();
        observe_frame();
        chk("zero_d0", 32'(lows[0]), 32'd6);
        chk("zero_d1", 32'(lows[1]), 32'd0);

        // Two loads in one frame: last write wins.
        do_load(16'hAAAA, 4'h0);
        repeat (3) @(negedge clk);
        do_load(16'hBBBB, 4'h0);
        wait_fd();
        chk("pend_clear_at_fd", 32'(upd_pend), 32'd0);
        repeat (3) @(negedge clk);
        chk("show_b", 32'(seg), 32'b1100000);

        // Load on the wrap cycle while a previous load is pending.
        wait_fd();
        do_load(16'h6666, 4'h0);
        repeat (30) @(negedge clk);
        do_load(16'h7777, 4'h0);
        chk("wrap_fd", 32'(frame_done), 32'd1);
        chk("wrap_pend", 32'(upd_pend), 32'd1);
        repeat (3) @(negedge clk);
        chk("wrap_show_6", 32'(seg), 32'b0100000);
        wait_fd();
        chk("wrap_pend2", 32'(upd_pend), 32'd0);
        repeat (3) @(negedge clk);
        chk("wrap_show_7", 32'(seg), 32'b0001111);

        // Digit enables and decimal points.
        blank_lz = 1'b0;
        digit_en = 4'b0101;
        do_load(16'h1234, 4'b0010);
        wait_fd();
        observe_frame();
        chk("en_d3", 32'(lows[3]), 32'd0);
        chk("en_d1", 32'(lows[1]), 32'd0);
        chk("en_d2", 32'(lows[2]), 32'd6);
        chk("en_dp", 32'(dp_lows), 32'd0);

        // Reset in the middle of digit 2's slot.
        digit_en = 4'hF;
        do_load(16'h9999, 4'hF);
        repeat (20) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_an", 32'(an), 32'hF);
        chk("mid_rst_seg", 32'(seg), 32'h7F);
        chk("mid_rst_dp", 32'(dp), 32'd1);
        chk("mid_rst_pend", 32'(upd_pend), 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("resume_d0_an", 32'(an), 32'b1110);
        chk("resume_d0_seg", 32'(seg), 32'b0000001);

        // Randomized traffic against the model.
        repeat (3000) begin
            load    = ($urandom % 16 == 0);
            data_in = 16'($urandom);
            dp_in   = 4'($urandom);
            if ($urandom % 64 == 0) digit_en = 4'($urandom);
            if ($urandom % 64 == 0) blank_lz = 1'($urandom);
            rst     = ($urandom % 400 == 0);
            @(negedge clk);
        end
        load = 1'b0; rst = 1'b0;
        repeat (4) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
